// File: rtl/sprite_motion_ctrl_if.sv
// Frame/control inputs and offset/bounce/step outputs of sprite_motion_ctrl.
// With SPRITE_BTN_EN defined it also carries the manual button inputs.
interface sprite_motion_ctrl_if;
   logic               frame_tick;
   logic               enable;
   logic               pause;
   logic signed [10:0] row_offset;
   logic signed [10:0] column_offset;
   logic               row_bounce;
   logic               col_bounce;
   logic               step_done;
`ifdef SPRITE_BTN_EN
   logic               btn_up;
   logic               btn_down;
   logic               btn_left;
   logic               btn_right;
   logic               btn_mode;

   modport master (
      output frame_tick, enable, pause, btn_up, btn_down, btn_left, btn_right, btn_mode,
      input  row_offset, column_offset, row_bounce, col_bounce, step_done
   );
   modport slave (
      input  frame_tick, enable, pause, btn_up, btn_down, btn_left, btn_right, btn_mode,
      output row_offset, column_offset, row_bounce, col_bounce, step_done
   );
`else
   modport master (
      output frame_tick, enable, pause,
      input  row_offset, column_offset, row_bounce, col_bounce, step_done
   );
   modport slave (
      input  frame_tick, enable, pause,
      output row_offset, column_offset, row_bounce, col_bounce, step_done
   );
`endif
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Bouncing sprite offset generator: steps once every FRAMES_PER_STEP frame ticks.
// Optional SPRITE_BTN_EN adds a manual mode driven by debounced direction buttons.
//
// state   | meaning
// IDLE    | parked, offsets held, waits for enable
// RUN     | counting frame ticks, stepping on terminal count
// HOLD    | paused, offsets/direction/counter frozen
module sprite_motion_ctrl #(
   parameter int BASE_ROW        = 100,
   parameter int BASE_COL        = 100,
   parameter int SPR_H           = 2,
   parameter int SPR_W           = 2,
   parameter int V_RES           = 480,
   parameter int H_RES           = 640,
   parameter int STEP            = 1,
   parameter int FRAMES_PER_STEP = 1
) (
   input logic                 clk,
   input logic                 reset,
   sprite_motion_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   localparam logic signed [11:0] ROW_MIN = 12'(-BASE_ROW);
   localparam logic signed [11:0] ROW_MAX = 12'(V_RES - SPR_H - BASE_ROW);
   localparam logic signed [11:0] COL_MIN = 12'(-BASE_COL);
   localparam logic signed [11:0] COL_MAX = 12'(H_RES - SPR_W - BASE_COL);
   localparam logic signed [11:0] STEP_S  = 12'(STEP);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic signed [10:0] row_q, row_d, col_q, col_d;
   logic               row_neg_q, row_neg_d, col_neg_q, col_neg_d;
   logic               row_bnc_q, row_bnc_d, col_bnc_q, col_bnc_d;
   logic               done_q, done_d;
   logic               tick_run, step_fire;
   logic signed [11:0] row_nx, col_nx;

   function automatic logic signed [11:0] ext(input logic signed [10:0] v);
      return {v[10], v};
   endfunction

   function automatic logic signed [11:0] advance(input logic signed [10:0] v, input logic neg);
      return neg ? ext(v) - STEP_S : ext(v) + STEP_S;
   endfunction

`ifdef SPRITE_BTN_EN
   function automatic logic signed [11:0] btn_delta(input logic inc, input logic dec);
      if (inc && !dec) return STEP_S;
      if (dec && !inc) return -STEP_S;
      return '0;
   endfunction

   function automatic logic signed [11:0] clamp(input logic signed [11:0] v,
                                                input logic signed [11:0] lo,
                                                input logic signed [11:0] hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      row_neg_d = row_neg_q;
      col_neg_d = col_neg_q;
      row_bnc_d = 1'b0;
      col_bnc_d = 1'b0;
      done_d    = 1'b0;
      tick_run  = 1'b0;
      row_nx    = '0;
      col_nx    = '0;

      case (state_q)
         ST_RUN: begin
            if (!bus.enable)         state_d = ST_IDLE;
            else if (bus.pause)      state_d = ST_HOLD;
            else if (bus.frame_tick) tick_run = 1'b1;
         end
         ST_HOLD: begin
            if (!bus.enable)    state_d = ST_IDLE;
            else if (!bus.pause) state_d = ST_RUN;
         end
         default: begin
            if (bus.enable) state_d = ST_RUN;
         end
      endcase

      step_fire = tick_run && (cnt_q == CNT_LAST);
      if (tick_run) cnt_d = step_fire ? '0 : cnt_q + 1'b1;

      if (step_fire) begin
         done_d = 1'b1;
`ifdef SPRITE_BTN_EN
         // manual mode clamps at the limits and leaves bounce direction untouched
         if (bus.btn_mode) begin
            row_nx = clamp(ext(row_q) + btn_delta(bus.btn_down, bus.btn_up), ROW_MIN, ROW_MAX);
            col_nx = clamp(ext(col_q) + btn_delta(bus.btn_right, bus.btn_left), COL_MIN, COL_MAX);
            row_d  = row_nx[10:0];
            col_d  = col_nx[10:0];
         end else
`endif
         begin
            row_nx = advance(row_q, row_neg_q);
            col_nx = advance(col_q, col_neg_q);
            if (row_nx > ROW_MAX) begin
               row_d = ROW_MAX[10:0]; row_neg_d = 1'b1; row_bnc_d = 1'b1;
            end else if (row_nx < ROW_MIN) begin
               row_d = ROW_MIN[10:0]; row_neg_d = 1'b0; row_bnc_d = 1'b1;
            end else begin
               row_d = row_nx[10:0];
            end
            if (col_nx > COL_MAX) begin
               col_d = COL_MAX[10:0]; col_neg_d = 1'b1; col_bnc_d = 1'b1;
            end else if (col_nx < COL_MIN) begin
               col_d = COL_MIN[10:0]; col_neg_d = 1'b0; col_bnc_d = 1'b1;
            end else begin
               col_d = col_nx[10:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         row_neg_q <= 1'b0;
         col_neg_q <= 1'b0;
         row_bnc_q <= 1'b0;
         col_bnc_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         row_neg_q <= row_neg_d;
         col_neg_q <= col_neg_d;
         row_bnc_q <= row_bnc_d;
         col_bnc_q <= col_bnc_d;
         done_q    <= done_d;
      end
   end

   assign bus.row_offset    = row_q;
   assign bus.column_offset = col_q;
   assign bus.row_bounce    = row_bnc_q;
   assign bus.col_bounce    = col_bnc_q;
   assign bus.step_done     = done_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (default, and FRAMES_PER_STEP=4/STEP=3 with
// equal row/column limits) checked every cycle against a behavioural model.
module tb_sprite_motion_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tk = 1'b0, en = 1'b0, ps = 1'b0;
   logic bm = 1'b0, bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
   int   total = 0, bad = 0;
   int   sd0_n = 0, sd1_n = 0, rb0_n = 0;

   always #5 clk = ~clk;

   sprite_motion_ctrl_if if0();
   sprite_motion_ctrl_if if1();

   assign if0.frame_tick = tk;
   assign if0.enable     = en;
   assign if0.pause      = ps;
   assign if1.frame_tick = tk;
   assign if1.enable     = en;
   assign if1.pause      = ps;
`ifdef SPRITE_BTN_EN
   assign if0.btn_mode = bm;  assign if1.btn_mode = bm;
   assign if0.btn_up   = bu;  assign if1.btn_up   = bu;
   assign if0.btn_down = bd;  assign if1.btn_down = bd;
   assign if0.btn_left = bl;  assign if1.btn_left = bl;
   assign if0.btn_right = br; assign if1.btn_right = br;
`endif

   sprite_motion_ctrl u0 (.clk(clk), .reset(reset), .bus(if0));
   sprite_motion_ctrl #(.FRAMES_PER_STEP(4), .STEP(3), .H_RES(480))
      u1 (.clk(clk), .reset(reset), .bus(if1));

   // mode: 0 parked, 1 running, 2 paused; dir is +1/-1
   typedef struct packed {
      int mode; int cnt; int row; int col; int rdir; int cdir; int rb; int cb; int sd;
   } mdl_t;
   mdl_t m0, m1;

   function automatic void bounce_axis(inout int off, inout int dir, output int b,
                                       input int stp, input int lo, input int hi);
      int nx;
      nx = off + dir * stp;
      b  = 0;
      if (nx > hi)      begin off = hi; dir = -1; b = 1; end
      else if (nx < lo) begin off = lo; dir = 1;  b = 1; end
      else              off = nx;
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int fps, input int stp,
                                  input int rmax, input int cmax);
      mdl_t n;
      int r, rd, rbv, c, cd, cbv;
      n = m; n.rb = 0; n.cb = 0; n.sd = 0;
      if (reset) begin
         n.mode = 0; n.cnt = 0; n.row = 0; n.col = 0; n.rdir = 1; n.cdir = 1;
         return n;
      end
      if (m.mode == 0) begin
         if (en) n.mode = 1;
      end else if (m.mode == 2) begin
         if (!en) n.mode = 0; else if (!ps) n.mode = 1;
      end else if (!en) n.mode = 0;
      else if (ps) n.mode = 2;
      else if (tk) begin
         if (m.cnt == fps - 1) begin
            n.cnt = 0; n.sd = 1;
            if (bm) begin
               n.row = clampi(m.row + stp * (int'(bd) - int'(bu)), -100, rmax);
               n.col = clampi(m.col + stp * (int'(br) - int'(bl)), -100, cmax);
            end else begin
               r = m.row; rd = m.rdir; c = m.col; cd = m.cdir;
               bounce_axis(r, rd, rbv, stp, -100, rmax);
               bounce_axis(c, cd, cbv, stp, -100, cmax);
               n.row = r; n.rdir = rd; n.rb = rbv;
               n.col = c; n.cdir = cd; n.cb = cbv;
            end
         end else n.cnt = m.cnt + 1;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      m0 = mstep(m0, 1, 1, 378, 538);
      m1 = mstep(m1, 4, 3, 378, 378);
      #1;
      chk("u0_row", if0.row_offset, m0.row);
      chk("u0_col", if0.column_offset, m0.col);
      chk("u0_row_bounce", if0.row_bounce, m0.rb);
      chk("u0_col_bounce", if0.col_bounce, m0.cb);
      chk("u0_step_done", if0.step_done, m0.sd);
      chk("u1_row", if1.row_offset, m1.row);
      chk("u1_col", if1.column_offset, m1.col);
      chk("u1_row_bounce", if1.row_bounce, m1.rb);
      chk("u1_col_bounce", if1.col_bounce, m1.cb);
      chk("u1_step_done", if1.step_done, m1.sd);
      sd0_n += int'(if0.step_done);
      sd1_n += int'(if1.step_done);
      rb0_n += int'(if0.row_bounce);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         tk = 1'b1; cycle();
         tk = 1'b0; cycle();
      end
   endtask

   initial begin
      m0 = '0; m1 = '0;
      // reset, then ticks while disabled
      reset = 1'b1; repeat (3) cycle();
      reset = 1'b0; en = 1'b0; sd0_n = 0;
      tick(10);
      chk("t1_row", if0.row_offset, 0);
      chk("t1_col", if0.column_offset, 0);
      chk("t1_steps", sd0_n, 0);

      // basic stepping
      en = 1'b1; cycle(); sd0_n = 0;
      tick(5);
      chk("t2_row", if0.row_offset, 5);
      chk("t2_col", if0.column_offset, 5);
      chk("t2_steps", sd0_n, 5);

      // run up to the bottom edge and bounce
      tick(372);
      chk("t3_row377", if0.row_offset, 377);
      rb0_n = 0;
      tick(1);
      chk("t3_row378", if0.row_offset, 378);
      chk("t3_no_bounce_yet", rb0_n, 0);
      tick(1);
      chk("t3_row_flip", if0.row_offset, 378);
      chk("t3_bounce_once", rb0_n, 1);
      chk("t3_col", if0.column_offset, 379);
      tick(1);
      chk("t3_row_down", if0.row_offset, 377);
      chk("t3_col_up", if0.column_offset, 380);

      // frame divider and pause on u1
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; cycle(); sd1_n = 0;
      tick(8);
      chk("t4_steps_8", sd1_n, 2);
      sd1_n = 0;
      tick(2);
      ps = 1'b1; tick(4);
      ps = 1'b0; cycle();
      tick(2);
      chk("t4_steps_paused", sd1_n, 1);
      chk("t4_row1", if1.row_offset, 9);

      // reset mid-run, then enable drop coincident with a tick
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; cycle();
      tick(50);
      chk("t5_row50", if0.row_offset, 50);
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("t5_rst_row", if0.row_offset, 0);
      chk("t5_rst_col", if0.column_offset, 0);
      cycle(); tick(1);
      chk("t5_dir_row", if0.row_offset, 1);
      chk("t5_dir_col", if0.column_offset, 1);
      sd0_n = 0;
      en = 1'b0; tk = 1'b1; cycle(); tk = 1'b0; cycle();
      chk("t5_drop_steps", sd0_n, 0);
      chk("t5_drop_row", if0.row_offset, 1);

`ifdef SPRITE_BTN_EN
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; cycle();
      bm = 1'b1; bu = 1'b1; rb0_n = 0;
      tick(150);
      chk("t6_row_clamp", if0.row_offset, -100);
      chk("t6_no_bounce", rb0_n, 0);
      chk("t6_col_still", if0.column_offset, 0);
      bu = 1'b0; bl = 1'b1; br = 1'b1; sd0_n = 0;
      tick(5);
      chk("t6_lr_col", if0.column_offset, 0);
      chk("t6_lr_steps", sd0_n, 5);
      bl = 1'b0; br = 1'b0; bm = 1'b0;
`endif

      // randomized traffic
      en = 1'b1;
      repeat (4000) begin
         tk    = 1'($urandom_range(0, 1));
         en    = ($urandom_range(0, 19) != 0);
         ps    = ($urandom_range(0, 29) == 0);
         reset = ($urandom_range(0, 1999) == 0);
`ifdef SPRITE_BTN_EN
         bm = ($urandom_range(0, 9) == 0);
         bu = 1'($urandom_range(0, 1)); bd = 1'($urandom_range(0, 1));
         bl = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
`endif
         cycle();
      end
      reset = 1'b0; tk = 1'b0;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
